// File: rtl/data_bus_ctrl.sv
// Data-port bus controller: inserts RAM read wait states and decodes a small
// memory-mapped I/O window (LEDR, SW, KEY, cycle counter, HEX digits).
module data_bus_ctrl #(
    parameter int                   WORD_SIZE   = 16,
    parameter int                   ADDR_BITS   = 12,
    parameter int                   RAM_LATENCY = 1,
    parameter logic [WORD_SIZE-1:0] IO_BASE     = 16'hF000,
    parameter int                   NUM_HEX     = 6
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   ReadData,
    input  logic                   WriteData,
    input  logic [WORD_SIZE-1:0]   DataAddr,
    input  logic [WORD_SIZE-1:0]   DataOut,
    output logic [WORD_SIZE-1:0]   DataIn,
    output logic                   DataWaitreq,
    output logic [ADDR_BITS-1:0]   RamAddr,
    output logic [WORD_SIZE-1:0]   RamWrData,
    output logic                   RamWe,
    input  logic [WORD_SIZE-1:0]   RamQ,
    input  logic [9:0]             SW,
    input  logic [3:0]             KEY,
    output logic [9:0]             LEDR,
    output logic [7*NUM_HEX-1:0]   HEX
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] LAT_M1    = 3'(RAM_LATENCY - 1);
    localparam logic [4:0] OFF_LEDR  = 5'd0;
    localparam logic [4:0] OFF_SW    = 5'd1;
    localparam logic [4:0] OFF_KEY   = 5'd2;
    localparam logic [4:0] OFF_CYC   = 5'd3;
    localparam logic [4:0] DIG_FIRST = 5'd8;
    localparam logic [4:0] DIG_LAST  = 5'(8 + NUM_HEX - 1);
    localparam int         DIG_IW    = (NUM_HEX > 1) ? $clog2(NUM_HEX) : 1;

    state_t                 r_state;
    state_t                 w_next;
    logic [2:0]             r_cnt;
    logic [2:0]             w_cnt_next;
    logic                   w_wait;
    logic                   w_done;

    logic                   w_io;
    logic                   w_ram;
    logic [4:0]             w_off;
    logic                   w_io_we;
    logic                   w_ram_rd;
    logic                   w_io_rd;
    logic                   w_is_dig;
    logic [DIG_IW-1:0]      w_dig_idx;
    logic [WORD_SIZE-1:0]   w_io_rdata;

    logic [9:0]             r_ledr;
    logic [9:0]             r_sw_s1;
    logic [9:0]             r_sw_s2;
    logic [3:0]             r_key_s1;
    logic [3:0]             r_key_s2;
    logic [WORD_SIZE-1:0]   r_cycles;
    logic [4:0]             r_dig [NUM_HEX];

    // Region decode
    always_comb begin
        w_io      = (DataAddr >= IO_BASE);
        w_ram     = ~w_io;
        w_off     = DataAddr[4:0];
        w_io_we   = WriteData & w_io;
        w_ram_rd  = ReadData & ~WriteData & w_ram;
        w_io_rd   = ReadData & ~WriteData & w_io;
        w_is_dig  = (w_off >= DIG_FIRST) && (w_off <= DIG_LAST);
        w_dig_idx = DIG_IW'(w_off - DIG_FIRST);
    end

    assign RamAddr   = DataAddr[ADDR_BITS-1:0];
    assign RamWrData = DataOut;
    assign RamWe     = Reset & WriteData & w_ram;

    // RAM read sequencer
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_wait     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ram_rd) begin
                    w_wait     = 1'b1;
                    w_cnt_next = LAT_M1;
                    w_next     = (RAM_LATENCY == 1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                w_wait     = 1'b1;
                w_cnt_next = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign DataWaitreq = Reset & w_wait;

    // I/O read mux, zero-extended to the bus width
    always_comb begin
        w_io_rdata = '0;
        case (w_off)
            OFF_LEDR: w_io_rdata[9:0] = r_ledr;
            OFF_SW:   w_io_rdata[9:0] = r_sw_s2;
            OFF_KEY:  w_io_rdata[3:0] = r_key_s2;
            OFF_CYC:  w_io_rdata      = r_cycles;
            default: begin
                if (w_is_dig) begin
                    w_io_rdata[4:0] = r_dig[w_dig_idx];
                end
            end
        endcase
    end

    always_comb begin
        DataIn = '0;
        if (w_done) begin
            DataIn = RamQ;
        end else if ((r_state == S_IDLE) && w_io_rd) begin
            DataIn = w_io_rdata;
        end
    end

    // I/O registers; a counter write overrides that cycle's increment
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_ledr   <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_key_s1 <= '0;
            r_key_s2 <= '0;
            r_cycles <= '0;
            for (int unsigned i = 0; i < NUM_HEX; i++) begin
                r_dig[i] <= 5'h10;
            end
        end else begin
            r_sw_s1  <= SW;
            r_sw_s2  <= r_sw_s1;
            r_key_s1 <= ~KEY;
            r_key_s2 <= r_key_s1;
            r_cycles <= r_cycles + WORD_SIZE'(1);
            if (w_io_we) begin
                case (w_off)
                    OFF_LEDR: r_ledr   <= DataOut[9:0];
                    OFF_CYC:  r_cycles <= '0;
                    default: begin
                        if (w_is_dig) begin
                            r_dig[w_dig_idx] <= DataOut[4:0];
                        end
                    end
                endcase
            end
        end
    end

    assign LEDR = r_ledr;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        HEX = '1;
        for (int unsigned i = 0; i < NUM_HEX; i++) begin
            HEX[7*i +: 7] = r_dig[i][4] ? 7'h7F : seg7(r_dig[i][3:0]);
        end
    end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Bench for data_bus_ctrl: three instances (RAM_LATENCY 1, 3, 4) share one
// stimulus stream; a transaction-level model predicts every output each cycle.
module tb_data_bus_ctrl;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReadData;
    logic        WriteData;
    logic [15:0] DataAddr;
    logic [15:0] DataOut;
    logic [9:0]  SW;
    logic [3:0]  KEY;

    logic [15:0] din   [3];
    logic        wreq  [3];
    logic [11:0] raddr [3];
    logic [15:0] rwd   [3];
    logic        rwe   [3];
    logic [15:0] ramq  [3];
    logic [9:0]  ledr  [3];
    logic [41:0] hex   [3];

    int n_pass  = 0;
    int n_total = 0;

    always #5 Clock = ~Clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LATG = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        logic [15:0] mem  [4096];
        logic [15:0] pipe [4];

        data_bus_ctrl #(
            .WORD_SIZE   (16),
            .ADDR_BITS   (12),
            .RAM_LATENCY (LATG),
            .IO_BASE     (16'hF000),
            .NUM_HEX     (6)
        ) u_dut (
            .Clock       (Clock),
            .Reset       (Reset),
            .ReadData    (ReadData),
            .WriteData   (WriteData),
            .DataAddr    (DataAddr),
            .DataOut     (DataOut),
            .DataIn      (din[g]),
            .DataWaitreq (wreq[g]),
            .RamAddr     (raddr[g]),
            .RamWrData   (rwd[g]),
            .RamWe       (rwe[g]),
            .RamQ        (ramq[g]),
            .SW          (SW),
            .KEY         (KEY),
            .LEDR        (ledr[g]),
            .HEX         (hex[g])
        );

        // Synchronous RAM: Q reflects the address LATG edges later
        always @(posedge Clock) begin
            if (rwe[g]) mem[raddr[g]] <= rwd[g];
            pipe[0] <= mem[raddr[g]];
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign ramq[g] = pipe[LATG-1];
    end

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h, want %0h", nm, k, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [6:0]  GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          cyc      = 0;
    bit          m_valid  = 1'b0;
    int          t0 [3]   = '{-1, -1, -1};
    logic [15:0] rdat [3];
    logic [15:0] exp_mem [4096];
    logic [9:0]  m_led, m_sw1, m_sw2;
    logic [3:0]  m_k1, m_k2;
    logic [4:0]  m_dig [6];
    int          last_clr = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic logic [15:0] io_val(input logic [4:0] off);
        int o;
        o = int'(off);
        if (o == 0) return {6'b0, m_led};
        if (o == 1) return {6'b0, m_sw2};
        if (o == 2) return {12'b0, m_k2};
        if (o == 3) return 16'(cyc - last_clr);
        if (o >= 8 && o <= 13) return {11'b0, m_dig[o-8]};
        return 16'h0000;
    endfunction

    function automatic logic [41:0] exp_hex();
        logic [41:0] h;
        for (int d = 0; d < 6; d++) h[7*d +: 7] = m_dig[d][4] ? 7'h7F : GLYPH[m_dig[d][3:0]];
        return h;
    endfunction

    always @(negedge Clock) begin : p_compare
        bit          io, rd_only, e_wait, e_we;
        logic [15:0] e_din;
        io      = (DataAddr >= 16'hF000);
        rd_only = ReadData && !WriteData;
        e_we    = Reset && WriteData && !io;
        for (int k = 0; k < 3; k++) begin
            e_wait = 1'b0;
            e_din  = 16'h0000;
            if (!Reset) begin
                t0[k] = -1;
            end else if (t0[k] >= 0) begin
                if (cyc - t0[k] < lat_of(k)) e_wait = 1'b1;
                else begin
                    e_din = rdat[k];
                    t0[k] = -1;
                end
            end else if (rd_only && !io) begin
                e_wait  = 1'b1;
                t0[k]   = cyc;
                rdat[k] = exp_mem[DataAddr[11:0]];
            end else if (rd_only) begin
                e_din = io_val(DataAddr[4:0]);
            end
            if (m_valid) begin
                chk("DataWaitreq", k, wreq[k], e_wait);
                chk("RamWe", k, rwe[k], e_we);
                chk("RamAddr", k, raddr[k], DataAddr[11:0]);
                chk("RamWrData", k, rwd[k], DataOut);
                chk("LEDR", k, ledr[k], m_led);
                chk("HEX", k, hex[k], exp_hex());
                if (Reset) chk("DataIn", k, din[k], e_din);
            end
        end
        // state that the coming clock edge will establish
        if (!Reset) begin
            m_valid  = 1'b1;
            m_led    = '0;
            m_sw1    = '0;
            m_sw2    = '0;
            m_k1     = '0;
            m_k2     = '0;
            last_clr = cyc + 1;
            for (int d = 0; d < 6; d++) m_dig[d] = 5'h10;
        end else begin
            if (WriteData && io) begin
                if (DataAddr[4:0] == 5'd0) m_led = DataOut[9:0];
                if (DataAddr[4:0] == 5'd3) last_clr = cyc + 1;
                if (DataAddr[4:0] >= 5'd8 && DataAddr[4:0] <= 5'd13)
                    m_dig[int'(DataAddr[4:0]) - 8] = DataOut[4:0];
            end
            if (WriteData && !io) exp_mem[DataAddr[11:0]] = DataOut;
            m_sw2 = m_sw1;
            m_sw1 = SW;
            m_k2  = m_k1;
            m_k1  = ~KEY;
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        ReadData  = rd;
        WriteData = wr;
        DataAddr  = a;
        DataOut   = d;
    endtask

    initial begin
        Reset = 1'b0;
        SW    = '0;
        KEY   = 4'hF;
        drive(0, 0, 16'h0000, 16'h0000);
        repeat (3) tick();
        Reset = 1'b1;
        @(negedge Clock);
        for (int k = 0; k < 3; k++) begin
            chk("rst_LEDR", k, ledr[k], 10'h000);
            chk("rst_HEX", k, hex[k], 42'h3FF_FFFF_FFFF);
            chk("rst_wait", k, wreq[k], 1'b0);
        end
        tick();

        // RAM writes
        drive(0, 1, 16'h0005, 16'h1234);
        @(negedge Clock);
        chk("wr_RamWe", 0, rwe[0], 1'b1);
        chk("wr_wait", 0, wreq[0], 1'b0);
        tick();
        drive(0, 1, 16'h0010, 16'hBEEF);
        tick();
        drive(0, 0, 16'h0000, 16'h0000);
        @(negedge Clock);
        chk("idle_RamWe", 0, rwe[0], 1'b0);
        tick();

        // Latency-1 read of 0x005
        drive(1, 0, 16'h0005, 16'h0000);
        @(negedge Clock);
        chk("l1_wait_T", 0, wreq[0], 1'b1);
        tick();
        @(negedge Clock);
        chk("l1_wait_T1", 0, wreq[0], 1'b0);
        chk("l1_data", 0, din[0], 16'h1234);
        tick();
        drive(0, 0, 16'h0000, 16'h0000);
        repeat (5) tick();

        // Latency-3 reads of 0x010, request held so a second read follows
        drive(1, 0, 16'h0010, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            chk("l3_wait", 1, wreq[1], (i != 3));
            if (i == 3) chk("l3_data", 1, din[1], 16'hBEEF);
            tick();
        end
        drive(0, 0, 16'h0000, 16'h0000);
        repeat (5) tick();

        // I/O writes: LEDR, digit 0 = 'C', digit 1 blanked
        drive(0, 1, 16'hF000, 16'h02A5);
        tick();
        drive(0, 1, 16'hF008, 16'h000C);
        tick();
        drive(0, 1, 16'hF009, 16'h0010);
        tick();
        drive(1, 0, 16'hF000, 16'h0000);
        @(negedge Clock);
        chk("io_LEDR", 0, ledr[0], 10'h2A5);
        chk("io_HEX0", 0, hex[0][6:0], 7'h46);
        chk("io_HEX1", 0, hex[0][13:7], 7'h7F);
        chk("io_rd_LEDR", 0, din[0], 16'h02A5);
        chk("io_wait", 0, wreq[0], 1'b0);
        tick();

        // Synchronised SW / KEY
        SW  = 10'h3C1;
        KEY = 4'b1110;
        drive(0, 0, 16'h0000, 16'h0000);
        repeat (3) tick();
        drive(1, 0, 16'hF001, 16'h0000);
        @(negedge Clock);
        chk("rd_SW", 0, din[0], 16'h03C1);
        tick();
        drive(1, 0, 16'hF002, 16'h0000);
        @(negedge Clock);
        chk("rd_KEY", 0, din[0], 16'h0001);
        tick();

        // Cycle counter, unmapped and read-only offsets
        drive(0, 1, 16'hF003, 16'h0000);
        tick();
        drive(0, 0, 16'h0000, 16'h0000);
        repeat (5) tick();
        drive(1, 0, 16'hF003, 16'h0000);
        @(negedge Clock);
        chk("cnt5", 0, din[0], 16'd5);
        tick();
        drive(1, 0, 16'hF01F, 16'h0000);
        @(negedge Clock);
        chk("unmapped", 0, din[0], 16'h0000);
        tick();
        drive(0, 1, 16'hF01F, 16'hFFFF);
        tick();
        drive(0, 1, 16'hF001, 16'hFFFF);
        tick();
        drive(1, 0, 16'hF000, 16'h0000);
        @(negedge Clock);
        chk("led_kept", 0, din[0], 16'h02A5);
        tick();
        drive(0, 1, 16'hF003, 16'h0000);
        tick();
        drive(1, 0, 16'hF003, 16'h0000);
        repeat (65535) tick();
        @(negedge Clock);
        chk("cnt_ffff", 0, din[0], 16'hFFFF);
        tick();
        @(negedge Clock);
        chk("cnt_wrap", 0, din[0], 16'h0000);
        tick();

        // Read and write together on RAM: write wins
        drive(1, 1, 16'h0020, 16'h5A5A);
        @(negedge Clock);
        chk("rw_RamWe", 0, rwe[0], 1'b1);
        chk("rw_wait", 0, wreq[0], 1'b0);
        chk("rw_data", 0, din[0], 16'h0000);
        tick();
        drive(1, 0, 16'h0020, 16'h0000);
        tick();
        @(negedge Clock);
        chk("rw_readback", 0, din[0], 16'h5A5A);
        tick();
        drive(0, 0, 16'h0000, 16'h0000);
        repeat (5) tick();

        // Reset during a latency-4 read
        drive(1, 0, 16'h0005, 16'h0000);
        tick();
        @(negedge Clock);
        chk("l4_wait", 2, wreq[2], 1'b1);
        tick();
        Reset = 1'b0;
        drive(0, 1, 16'h0030, 16'h1111);
        @(negedge Clock);
        chk("rstlo_wait", 2, wreq[2], 1'b0);
        chk("rstlo_RamWe", 2, rwe[2], 1'b0);
        tick();
        Reset = 1'b1;
        drive(0, 0, 16'h0000, 16'h0000);
        @(negedge Clock);
        chk("abort_wait", 2, wreq[2], 1'b0);
        chk("abort_data", 2, din[2], 16'h0000);
        chk("abort_LEDR", 2, ledr[2], 10'h000);
        chk("abort_HEX", 2, hex[2], 42'h3FF_FFFF_FFFF);
        tick();
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
